pc_fetch_unit: RTL and testbench

Fetch-side consumer of the branch/jump redirect, the other end of the BRANCH_JUMP_MUX / BRANCH_JUMP_OUT interface. It owns the program counter, issues instruction-memory reads, and handles memory busywait and pipeline stalls. It applies taken branches and jumps from the EX stage, including redirects that arrive while a fetch is still in flight. It feeds the IF/ID pipeline register and drives the IF/ID flush.

---
 rtl/pc_fetch_unit_pkg.sv | 24 ++
 rtl/pc_fetch_unit_if.sv | 23 ++
 rtl/pc_fetch_unit_pc_next_sel.sv | 71 +++++++
 rtl/pc_fetch_unit.sv | 98 +++++++++
 tb/tb_pc_fetch_unit.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch unit: state encoding, default constants,
// IF/ID update actions and a redirect-target alignment helper.
package pc_fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP           = 32'd4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        IFID_HOLD,
        IFID_BUBBLE,
        IFID_LOAD
    } ifid_act_e;

    // No compressed ISA, so redirect targets are always word aligned.
    function automatic logic [31:0] align_target(input logic [31:0] target);
        return target & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and memory (slave).
interface pc_fetch_unit_if;

    logic        IMEM_READ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_BUSYWAIT;
    logic [31:0] IMEM_READDATA;

    modport master (
        output IMEM_READ,
        output IMEM_ADDR,
        input  IMEM_BUSYWAIT,
        input  IMEM_READDATA
    );

    modport slave (
        input  IMEM_READ,
        input  IMEM_ADDR,
        output IMEM_BUSYWAIT,
        output IMEM_READDATA
    );

endinterface

// File: rtl/pc_fetch_unit_pc_next_sel.sv
// Combinational next-PC / next-state selection for the fetch unit.
// Decides how the PC, target latch and IF/ID register move on the next edge.
module pc_fetch_unit_pc_next_sel
    import pc_fetch_unit_pkg::*;
(
    input  logic [1:0]  state_q,
    input  logic [31:0] pc_q,
    input  logic [31:0] target_q,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        stall,
    input  logic        busywait,
    output logic [1:0]  state_d,
    output logic [31:0] pc_d,
    output logic [31:0] target_d,
    output logic        flush_d,
    output ifid_act_e   ifid_act
);

    logic [31:0] new_target;

    assign new_target = align_target(redirect_target);

    // Priority decode: redirect beats stall, stall beats busywait, then normal advance.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        flush_d  = 1'b0;
        ifid_act = IFID_HOLD;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (redirect && !busywait) begin
                    pc_d     = new_target;
                    flush_d  = 1'b1;
                    ifid_act = IFID_BUBBLE;
                end else if (redirect) begin
                    target_d = new_target;
                    flush_d  = 1'b1;
                    ifid_act = IFID_BUBBLE;
                    state_d  = ST_DRAIN;
                end else if (stall) begin
                    ifid_act = IFID_HOLD;
                end else if (busywait) begin
                    ifid_act = IFID_BUBBLE;
                end else begin
                    pc_d     = pc_q + PC_STEP;
                    ifid_act = IFID_LOAD;
                end
            end
            ST_DRAIN: begin
                ifid_act = IFID_BUBBLE;
                if (redirect) begin
                    target_d = new_target;
                    flush_d  = 1'b1;
                end
                if (!busywait) begin
                    pc_d    = redirect ? new_target : target_q;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch unit top: owns the PC, drives instruction-memory reads, applies
// branch/jump redirects (including during an in-flight access) and feeds IF/ID.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   BRANCH_JUMP_MUX,
    input  logic [31:0]            BRANCH_JUMP_OUT,
    input  logic                   STALL,
    pc_fetch_unit_if.master        imem,
    output logic [31:0]            PC,
    output logic [31:0]            PC_PLUS4,
    output logic [31:0]            INSTRUCTION,
    output logic [31:0]            INSTR_PC,
    output logic                   INSTR_VALID,
    output logic                   FLUSH
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        flush_q, flush_d;
    ifid_act_e   ifid_act;

    pc_fetch_unit_pc_next_sel u_next_sel (
        .state_q         (state_q),
        .pc_q            (pc_q),
        .target_q        (target_q),
        .redirect        (BRANCH_JUMP_MUX),
        .redirect_target (BRANCH_JUMP_OUT),
        .stall           (STALL),
        .busywait        (imem.IMEM_BUSYWAIT),
        .state_d         (state_d),
        .pc_d            (pc_d),
        .target_d        (target_d),
        .flush_d         (flush_d),
        .ifid_act        (ifid_act)
    );

    // Translate the selected IF/ID action into next register contents.
    always_comb begin
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        case (ifid_act)
            IFID_BUBBLE: begin
                instr_d       = NOP_INSTR;
                instr_valid_d = 1'b0;
            end
            IFID_LOAD: begin
                instr_d       = imem.IMEM_READDATA;
                instr_pc_d    = pc_q;
                instr_valid_d = 1'b1;
            end
            default: begin
                instr_d = instr_q;
            end
        endcase
    end

    // All fetch state; reset abandons any in-flight access immediately.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            target_q      <= 32'h0000_0000;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            target_q      <= target_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            flush_q       <= flush_d;
        end
    end

    assign imem.IMEM_READ = (state_q != ST_IDLE);
    assign imem.IMEM_ADDR = pc_q;
    assign PC             = pc_q;
    assign PC_PLUS4       = pc_q + PC_STEP;
    assign INSTRUCTION    = instr_q;
    assign INSTR_PC       = instr_pc_q;
    assign INSTR_VALID    = instr_valid_q;
    assign FLUSH          = flush_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: expected IF-stage snapshots are queued
// as each step is driven and compared once the clock edge has produced them.
module tb_pc_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic        valid;
        logic        flush;
        logic        read;
    } exp_t;

    logic        CLK;
    logic        RESET;
    logic        BRANCH_JUMP_MUX;
    logic [31:0] BRANCH_JUMP_OUT;
    logic        STALL;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic [31:0] INSTRUCTION;
    logic [31:0] INSTR_PC;
    logic        INSTR_VALID;
    logic        FLUSH;

    int checks = 0;
    int errors = 0;
    exp_t scoreboard[$];

    pc_fetch_unit_if imem ();

    pc_fetch_unit dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .BRANCH_JUMP_MUX (BRANCH_JUMP_MUX),
        .BRANCH_JUMP_OUT (BRANCH_JUMP_OUT),
        .STALL           (STALL),
        .imem            (imem),
        .PC              (PC),
        .PC_PLUS4        (PC_PLUS4),
        .INSTRUCTION     (INSTRUCTION),
        .INSTR_PC        (INSTR_PC),
        .INSTR_VALID     (INSTR_VALID),
        .FLUSH           (FLUSH)
    );

    // Memory contents: word at address A is 0xAAAA0001 + A/4.
    function automatic logic [31:0] word(input logic [31:0] addr);
        return 32'hAAAA_0001 + (addr >> 2);
    endfunction

    always #5 CLK = ~CLK;

    // Memory returns the word at whatever address the fetch unit presents.
    always_comb imem.IMEM_READDATA = word(imem.IMEM_ADDR);

    task automatic cmp(input string tag, input string field,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s.%s: observed %h expected %h", tag, field, obs, exp);
        end
    endtask

    task automatic pushExpected(input string tag, input logic [31:0] pc,
                                input logic [31:0] instr, input logic [31:0] ipc,
                                input logic valid, input logic flush, input logic read);
        exp_t e;
        e.tag = tag; e.pc = pc; e.instr = instr; e.ipc = ipc;
        e.valid = valid; e.flush = flush; e.read = read;
        scoreboard.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        checks++;
        assert (scoreboard.size() > 0)
        else begin
            errors++;
            $error("[TB] FAIL scoreboard: observed empty queue expected entry");
        end
        if (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            cmp(e.tag, "PC",          PC,                    e.pc);
            cmp(e.tag, "IMEM_ADDR",   imem.IMEM_ADDR,        e.pc);
            cmp(e.tag, "PC_PLUS4",    PC_PLUS4,              e.pc + 32'd4);
            cmp(e.tag, "INSTRUCTION", INSTRUCTION,           e.instr);
            cmp(e.tag, "INSTR_PC",    INSTR_PC,              e.ipc);
            cmp(e.tag, "INSTR_VALID", {31'd0, INSTR_VALID},  {31'd0, e.valid});
            cmp(e.tag, "FLUSH",       {31'd0, FLUSH},        {31'd0, e.flush});
            cmp(e.tag, "IMEM_READ",   {31'd0, imem.IMEM_READ}, {31'd0, e.read});
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge state, then check it.
    task automatic applyStimulus(input string tag, input logic mux, input logic [31:0] tgt,
                                 input logic stall, input logic busy,
                                 input logic [31:0] e_pc, input logic [31:0] e_instr,
                                 input logic [31:0] e_ipc, input logic e_valid,
                                 input logic e_flush);
        BRANCH_JUMP_MUX    = mux;
        BRANCH_JUMP_OUT    = tgt;
        STALL              = stall;
        imem.IMEM_BUSYWAIT = busy;
        pushExpected(tag, e_pc, e_instr, e_ipc, e_valid, e_flush, 1'b1);
        @(posedge CLK);
        @(negedge CLK);
        checkOutput();
    endtask

    initial begin
        CLK = 1'b0;
        RESET = 1'b0;
        BRANCH_JUMP_MUX = 1'b0;
        BRANCH_JUMP_OUT = 32'h0;
        STALL = 1'b0;
        imem.IMEM_BUSYWAIT = 1'b0;

        repeat (2) @(negedge CLK);
        pushExpected("reset", 32'h0, NOP, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput();

        RESET = 1'b1;
        //             tag          mux  target        stl  busy  PC            INSTR         INSTR_PC      V     F
        applyStimulus("idle2fetch", 1'b0, 32'h0,       1'b0, 1'b0, 32'h0000_0000, NOP,          32'h0,        1'b0, 1'b0);
        applyStimulus("seq0",       1'b0, 32'h0,       1'b0, 1'b0, 32'h0000_0004, 32'hAAAA0001, 32'h0,        1'b1, 1'b0);
        applyStimulus("seq4",       1'b0, 32'h0,       1'b0, 1'b0, 32'h0000_0008, 32'hAAAA0002, 32'h4,        1'b1, 1'b0);
        applyStimulus("redir100",   1'b1, 32'h100,     1'b0, 1'b0, 32'h0000_0100, NOP,          32'h4,        1'b0, 1'b1);
        applyStimulus("fetch100",   1'b0, 32'h0,       1'b0, 1'b0, 32'h0000_0104, 32'hAAAA0041, 32'h100,      1'b1, 1'b0);
        applyStimulus("redir10",    1'b1, 32'h10,      1'b0, 1'b0, 32'h0000_0010, NOP,          32'h100,      1'b0, 1'b1);
        applyStimulus("busyRedir",  1'b1, 32'h200,     1'b0, 1'b1, 32'h0000_0010, NOP,          32'h100,      1'b0, 1'b1);
        applyStimulus("drainBusy1", 1'b0, 32'h0,       1'b0, 1'b1, 32'h0000_0010, NOP,          32'h100,      1'b0, 1'b0);
        applyStimulus("drainBusy2", 1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0010, NOP,          32'h100,      1'b0, 1'b0);
        applyStimulus("drainDone",  1'b0, 32'h0,       1'b0, 1'b0, 32'h0000_0200, NOP,          32'h100,      1'b0, 1'b0);
        applyStimulus("fetch200",   1'b0, 32'h0,       1'b0, 1'b0, 32'h0000_0204, 32'hAAAA0081, 32'h200,      1'b1, 1'b0);
        applyStimulus("drainR300",  1'b1, 32'h300,     1'b0, 1'b1, 32'h0000_0204, NOP,          32'h200,      1'b0, 1'b1);
        applyStimulus("drainR400",  1'b1, 32'h400,     1'b0, 1'b1, 32'h0000_0204, NOP,          32'h200,      1'b0, 1'b1);
        applyStimulus("drainWait",  1'b0, 32'h0,       1'b0, 1'b1, 32'h0000_0204, NOP,          32'h200,      1'b0, 1'b0);
        applyStimulus("drainTo400", 1'b0, 32'h0,       1'b0, 1'b0, 32'h0000_0400, NOP,          32'h200,      1'b0, 1'b0);
        applyStimulus("fetch400",   1'b0, 32'h0,       1'b0, 1'b0, 32'h0000_0404, 32'hAAAA0101, 32'h400,      1'b1, 1'b0);
        applyStimulus("redir1C",    1'b1, 32'h1C,      1'b0, 1'b0, 32'h0000_001C, NOP,          32'h400,      1'b0, 1'b1);
        applyStimulus("fetch1C",    1'b0, 32'h0,       1'b0, 1'b0, 32'h0000_0020, 32'hAAAA0008, 32'h1C,       1'b1, 1'b0);
        applyStimulus("stall1",     1'b0, 32'h0,       1'b1, 1'b0, 32'h0000_0020, 32'hAAAA0008, 32'h1C,       1'b1, 1'b0);
        applyStimulus("stall2",     1'b0, 32'h0,       1'b1, 1'b0, 32'h0000_0020, 32'hAAAA0008, 32'h1C,       1'b1, 1'b0);
        applyStimulus("stallRedir", 1'b1, 32'hFFFFFFFC, 1'b1, 1'b0, 32'hFFFF_FFFC, NOP,        32'h1C,       1'b0, 1'b1);
        applyStimulus("wrapFetch",  1'b0, 32'h0,       1'b0, 1'b0, 32'h0000_0000, 32'hEAAA0000, 32'hFFFFFFFC, 1'b1, 1'b0);
        applyStimulus("align103",   1'b1, 32'h103,     1'b0, 1'b0, 32'h0000_0100, NOP,          32'hFFFFFFFC, 1'b0, 1'b1);
        applyStimulus("fetchBusy1", 1'b0, 32'h0,       1'b0, 1'b1, 32'h0000_0100, NOP,          32'hFFFFFFFC, 1'b0, 1'b0);
        applyStimulus("fetchBusy2", 1'b0, 32'h0,       1'b0, 1'b1, 32'h0000_0100, NOP,          32'hFFFFFFFC, 1'b0, 1'b0);

        RESET = 1'b0;
        #1;
        pushExpected("midReset", 32'h0, NOP, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput();

        @(negedge CLK);
        RESET = 1'b1;
        applyStimulus("rst2fetch",  1'b0, 32'h0,       1'b0, 1'b0, 32'h0000_0000, NOP,          32'h0,        1'b0, 1'b0);
        applyStimulus("rstSeq0",    1'b0, 32'h0,       1'b0, 1'b0, 32'h0000_0004, 32'hAAAA0001, 32'h0,        1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the bench can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: observed no completion expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
